// File: rtl/winograd_output_transform_if.sv
// Handshake and data bundle for the Winograd F(2x2,3x3) output transform.
// u/v carry one 4x4 channel beat in; y carries the 2x2 output tile out.
interface winograd_output_transform_if #(
  parameter int WIDTH = 16
);
  logic                                in_valid;
  logic                                in_ready;
  logic signed [0:3][0:3][WIDTH-1:0]   u;
  logic signed [0:3][0:3][WIDTH-1:0]   v;
  logic                                out_valid;
  logic                                out_ready;
  logic signed [0:1][0:1][WIDTH-1:0]   y;

  modport master (
    output in_valid, u, v, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, u, v, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/winograd_output_transform.sv
// Winograd F(2x2,3x3) output stage: accumulates NUM_CH element-wise U*V beats, then applies Y = A^T M A.
// Define WINO_OUT_SAT_EN to saturate the final WIDTH reduction instead of wrapping.
module winograd_output_transform #(
  parameter int WIDTH      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int NUM_CH     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  winograd_output_transform_if.slave  bus
);

  localparam int MW  = 2*WIDTH + $clog2(NUM_CH) + 4;
  localparam int EXT = MW - 2*WIDTH;
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {ACCUM, XFORM, OUT} state_e;

  state_e                      state_q;
  logic [CW-1:0]               ch_cnt_q;
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic [MW-1:0]               m_q    [4][4];
  logic [MW-1:0]               m_d    [4][4];
  logic [2*WIDTH-1:0]          prod   [4][4];
  logic [MW-1:0]               t      [2][4];
  logic signed [MW-1:0]        yfull  [2][2];
  logic signed [MW-1:0]        yshift [2][2];
  logic [0:1][0:1][WIDTH-1:0]  y_d;
  logic [0:1][0:1][WIDTH-1:0]  y_q;
  logic                        accept;
  logic                        first_beat;
  logic                        last_beat;

  assign accept     = bus.in_valid && in_ready_q;
  assign first_beat = (ch_cnt_q == '0);
  assign last_beat  = (ch_cnt_q == CW'(NUM_CH - 1));

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;

  // Operands are sign-extended to 2*WIDTH so the low half of the product is the exact signed result.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        prod[i][j] = {{WIDTH{bus.u[i][j][WIDTH-1]}}, bus.u[i][j]} *
                     {{WIDTH{bus.v[i][j][WIDTH-1]}}, bus.v[i][j]};
        m_d[i][j]  = first_beat ? {{EXT{prod[i][j][2*WIDTH-1]}}, prod[i][j]}
                                : m_q[i][j] + {{EXT{prod[i][j][2*WIDTH-1]}}, prod[i][j]};
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      t[0][c] = m_q[0][c] + m_q[1][c] + m_q[2][c];
      t[1][c] = m_q[1][c] - m_q[2][c] - m_q[3][c];
    end
    for (int r = 0; r < 2; r++) begin
      yfull[r][0]  = t[r][0] + t[r][1] + t[r][2];
      yfull[r][1]  = t[r][1] - t[r][2] - t[r][3];
      yshift[r][0] = yfull[r][0] >>> FRAC_WIDTH;
      yshift[r][1] = yfull[r][1] >>> FRAC_WIDTH;
    end
  end

`ifdef WINO_OUT_SAT_EN
  localparam logic signed [MW-1:0] MAXV = {{(MW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [MW-1:0] MINV = {{(MW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        if (yshift[r][c] > MAXV)      y_d[r][c] = {1'b0, {(WIDTH-1){1'b1}}};
        else if (yshift[r][c] < MINV) y_d[r][c] = {1'b1, {(WIDTH-1){1'b0}}};
        else                          y_d[r][c] = yshift[r][c][WIDTH-1:0];
      end
    end
  end
`else
  logic unused_yshift_hi;
  assign unused_yshift_hi = ^{yshift[0][0][MW-1:WIDTH], yshift[0][1][MW-1:WIDTH],
                              yshift[1][0][MW-1:WIDTH], yshift[1][1][MW-1:WIDTH]};

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        y_d[r][c] = yshift[r][c][WIDTH-1:0];
      end
    end
  end
`endif

  // The transform reads M directly, so M is only cleared by the next tile's first-beat overwrite.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      ch_cnt_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          m_q[i][j] <= '0;
        end
      end
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            m_q <= m_d;
            if (last_beat) begin
              ch_cnt_q   <= '0;
              in_ready_q <= 1'b0;
              state_q    <= XFORM;
            end else begin
              ch_cnt_q <= ch_cnt_q + CW'(1);
            end
          end
        end
        XFORM: begin
          y_q         <= y_d;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ACCUM;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_winograd_output_transform.sv
// Directed bench for winograd_output_transform: one NUM_CH=1 and one NUM_CH=4 instance on a shared clock.
// Inputs change and outputs are sampled on the falling edge; the design acts on the rising edge.
module tb_winograd_output_transform;

  localparam int WIDTH = 16;
  typedef logic [0:3][0:3][WIDTH-1:0] tile_t;

  logic clk = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;

  always #5 clk = ~clk;

  winograd_output_transform_if #(.WIDTH(WIDTH)) bus1 ();
  winograd_output_transform_if #(.WIDTH(WIDTH)) bus4 ();

  winograd_output_transform #(.WIDTH(WIDTH), .FRAC_WIDTH(8), .NUM_CH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  winograd_output_transform #(.WIDTH(WIDTH), .FRAC_WIDTH(8), .NUM_CH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  function automatic tile_t fillAll(input logic [WIDTH-1:0] val);
    tile_t tl;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        tl[i][j] = val;
    return tl;
  endfunction

  function automatic tile_t corner(input logic [WIDTH-1:0] val);
    tile_t tl;
    tl       = '0;
    tl[0][0] = val;
    return tl;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int which, input logic valid, input tile_t uIn,
                               input tile_t vIn, input logic outReady);
    if (which == 1) begin
      bus1.in_valid  = valid;
      bus1.u         = uIn;
      bus1.v         = vIn;
      bus1.out_ready = outReady;
    end else begin
      bus4.in_valid  = valid;
      bus4.u         = uIn;
      bus4.v         = vIn;
      bus4.out_ready = outReady;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Four accepted beats on the NUM_CH=4 instance, leaving the bench at the XFORM-cycle falling edge.
  task automatic feedTile4(input string tag, input tile_t uIn, input tile_t vIn, input logic outReady);
    for (int k = 0; k < 4; k++) begin
      checkOutput({tag, " in_ready beat"}, bus4.in_ready, 32'd1);
      applyStimulus(4, 1'b1, uIn, vIn, outReady);
      step();
    end
    applyStimulus(4, 1'b0, uIn, vIn, outReady);
    checkOutput({tag, " in_ready xform"}, bus4.in_ready, 32'd0);
    checkOutput({tag, " out_valid xform"}, bus4.out_valid, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1, 1'b0, '0, '0, 1'b0);
    applyStimulus(4, 1'b0, '0, '0, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    $display("[TB] reset state");
    checkOutput("rst in_ready4", bus4.in_ready, 32'd1);
    checkOutput("rst out_valid4", bus4.out_valid, 32'd0);
    checkOutput("rst y4", bus4.y, 32'd0);
    checkOutput("rst in_ready1", bus1.in_ready, 32'd1);
    checkOutput("rst out_valid1", bus1.out_valid, 32'd0);

    $display("[TB] NUM_CH=1 unit tile");
    applyStimulus(1, 1'b1, fillAll(16'h0100), fillAll(16'h0100), 1'b1);
    step();
    applyStimulus(1, 1'b0, '0, '0, 1'b1);
    checkOutput("unit out_valid edge1", bus1.out_valid, 32'd0);
    checkOutput("unit in_ready xform", bus1.in_ready, 32'd0);
    step();
    checkOutput("unit out_valid edge2", bus1.out_valid, 32'd1);
    checkOutput("unit y00", bus1.y[0][0], 32'h0900);
    checkOutput("unit y01", bus1.y[0][1], 32'hFD00);
    checkOutput("unit y10", bus1.y[1][0], 32'hFD00);
    checkOutput("unit y11", bus1.y[1][1], 32'h0100);
    step();
    checkOutput("unit out_valid done", bus1.out_valid, 32'd0);
    checkOutput("unit in_ready done", bus1.in_ready, 32'd1);

    $display("[TB] NUM_CH=1 overflow reduction");
    applyStimulus(1, 1'b1, fillAll(16'h7F00), fillAll(16'h0100), 1'b1);
    step();
    applyStimulus(1, 1'b0, '0, '0, 1'b1);
    step();
    checkOutput("ovf out_valid", bus1.out_valid, 32'd1);
`ifdef WINO_OUT_SAT_EN
    checkOutput("ovf y00", bus1.y[0][0], 32'h7FFF);
    checkOutput("ovf y01", bus1.y[0][1], 32'h8000);
    checkOutput("ovf y10", bus1.y[1][0], 32'h8000);
`else
    checkOutput("ovf y00", bus1.y[0][0], 32'h7700);
    checkOutput("ovf y01", bus1.y[0][1], 32'h8300);
    checkOutput("ovf y10", bus1.y[1][0], 32'h8300);
`endif
    checkOutput("ovf y11", bus1.y[1][1], 32'h7F00);
    step();

    $display("[TB] NUM_CH=4 corner accumulation");
    feedTile4("acc", corner(16'h0200), corner(16'h0180), 1'b1);
    step();
    checkOutput("acc in_ready out", bus4.in_ready, 32'd0);
    checkOutput("acc out_valid", bus4.out_valid, 32'd1);
    checkOutput("acc y00", bus4.y[0][0], 32'h0C00);
    checkOutput("acc y01", bus4.y[0][1], 32'h0000);
    checkOutput("acc y10", bus4.y[1][0], 32'h0000);
    checkOutput("acc y11", bus4.y[1][1], 32'h0000);
    step();
    checkOutput("acc in_ready back", bus4.in_ready, 32'd1);
    checkOutput("acc out_valid back", bus4.out_valid, 32'd0);

    $display("[TB] NUM_CH=4 backpressure");
    feedTile4("bp", corner(16'h0200), corner(16'h0180), 1'b0);
    step();
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp out_valid hold", bus4.out_valid, 32'd1);
      checkOutput("bp y00 hold", bus4.y[0][0], 32'h0C00);
      checkOutput("bp in_ready hold", bus4.in_ready, 32'd0);
      step();
    end
    checkOutput("bp out_valid last", bus4.out_valid, 32'd1);
    applyStimulus(4, 1'b0, '0, '0, 1'b1);
    step();
    checkOutput("bp in_ready after", bus4.in_ready, 32'd1);
    checkOutput("bp out_valid after", bus4.out_valid, 32'd0);

    $display("[TB] NUM_CH=4 reset mid-tile");
    applyStimulus(4, 1'b1, fillAll(16'h0100), fillAll(16'h0100), 1'b1);
    step();
    step();
    applyStimulus(4, 1'b0, '0, '0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("mid rst in_ready", bus4.in_ready, 32'd1);
    checkOutput("mid rst out_valid", bus4.out_valid, 32'd0);
    feedTile4("mid", corner(16'h0200), corner(16'h0180), 1'b1);
    step();
    checkOutput("mid out_valid", bus4.out_valid, 32'd1);
    checkOutput("mid y00", bus4.y[0][0], 32'h0C00);
    checkOutput("mid y11", bus4.y[1][1], 32'h0000);
    step();

    $display("[TB] NUM_CH=4 back-to-back tiles");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4, 1'b1, fillAll(16'h0100), fillAll(16'h0100), 1'b1);
      step();
    end
    applyStimulus(4, 1'b1, corner(16'h0100), corner(16'h0100), 1'b1);
    checkOutput("b2b in_ready xform", bus4.in_ready, 32'd0);
    step();
    checkOutput("b2b t1 out_valid", bus4.out_valid, 32'd1);
    checkOutput("b2b t1 y00", bus4.y[0][0], 32'h2400);
    checkOutput("b2b t1 y01", bus4.y[0][1], 32'hF400);
    step();
    checkOutput("b2b in_ready t2", bus4.in_ready, 32'd1);
    for (int k = 0; k < 4; k++) step();
    applyStimulus(4, 1'b0, '0, '0, 1'b1);
    checkOutput("b2b t2 xform", bus4.out_valid, 32'd0);
    step();
    checkOutput("b2b t2 out_valid", bus4.out_valid, 32'd1);
    checkOutput("b2b t2 y00", bus4.y[0][0], 32'h0400);
    checkOutput("b2b t2 y01", bus4.y[0][1], 32'h0000);
    checkOutput("b2b t2 y11", bus4.y[1][1], 32'h0000);
    step();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/winograd_output_transform.md
WINOGRAD_OUTPUT_TRANSFORM -- requirements
Module: winograd_output_transform

Interface
REQ-001 SHALL have parameter WIDTH, default 16: signed data width of U, V and Y elements.
REQ-002 SHALL have parameter FRAC_WIDTH, default 8: fractional bits (Q8.8 at defaults).
REQ-003 SHALL have parameter NUM_CH, default 4: input-channel beats accumulated per output tile; legal range is NUM_CH >= 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the U/V beat is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat.
REQ-008 SHALL have port u, input, signed [WIDTH-1:0] [0:3][0:3]: transformed filter tile, as produced by the filter-transform stage.
REQ-009 SHALL have port v, input, signed [WIDTH-1:0] [0:3][0:3]: transformed input tile, B^T d B.
REQ-010 SHALL have port out_valid, output, 1 bit: y is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts y.
REQ-012 SHALL have port y, output, signed [WIDTH-1:0] [0:1][0:1]: 2x2 output tile.

Function
REQ-013 SHALL implement a 3-state FSM: ACCUM -> XFORM -> OUT -> ACCUM.
REQ-014 ACCUM: in_ready SHALL be 1; a beat is accepted when in_valid && in_ready.
REQ-015 Each accepted beat SHALL form P[i][j] = u[i][j]*v[i][j] at full 2*WIDTH precision.
REQ-016 The first beat of a tile (ch_cnt==0) SHALL overwrite M with P; each later beat SHALL add P to M.
REQ-017 M SHALL be 2*WIDTH+$clog2(NUM_CH)+4 bits wide, and no internal overflow SHALL be possible.
REQ-018 ch_cnt SHALL increment on each accepted beat; on beat NUM_CH it SHALL wrap to 0 and the FSM SHALL enter XFORM.
REQ-019 XFORM (one cycle, in_ready=0) SHALL compute T = A^T M:
  - T0[c] = M0c+M1c+M2c
  - T1[c] = M1c-M2c-M3c
REQ-020 XFORM SHALL then compute Yr0 = Tr0+Tr1+Tr2 and Yr1 = Tr1-Tr2-Tr3.
REQ-021 Each Y element SHALL be arithmetically shifted right by FRAC_WIDTH (floor), reduced to WIDTH per REQ-030/031, and registered into y; the FSM SHALL then enter OUT.
REQ-022 OUT: out_valid SHALL be 1 and in_ready SHALL be 0; y SHALL be held stable until out_valid && out_ready.
REQ-023 The out_valid && out_ready handshake SHALL return the FSM to ACCUM on the next edge, with in_ready=1 in the following cycle.
REQ-024 Latency: out_valid SHALL rise on the 2nd rising edge after the cycle in which the last beat's handshake occurs.
REQ-025 Throughput: SHALL be one tile per NUM_CH+2 cycles with out_ready held at 1.
REQ-026 in_valid while in_ready=0 SHALL be ignored; upstream SHALL hold the beat.
REQ-027 With NUM_CH==1, every accepted beat SHALL go directly to XFORM.

Reset
REQ-028 With rst=1 at an edge, the block SHALL set state=ACCUM, ch_cnt=0, M=0, y=0, out_valid=0, and in_ready=1 in the cycle after reset deasserts.
REQ-029 Reset mid-tile or in OUT SHALL discard the partial accumulation or the pending y; no data from before reset SHALL carry into the next tile.

Configuration
REQ-030 With macro WINO_OUT_SAT_EN defined, WIDTH reduction SHALL saturate: values > 2^(WIDTH-1)-1 become 0x7FFF and values < -2^(WIDTH-1) become 0x8000 (at WIDTH=16).
REQ-031 With WINO_OUT_SAT_EN undefined, WIDTH reduction SHALL take the low WIDTH bits (two's-complement wrap).

Verification
REQ-032 The bench SHALL check: NUM_CH=1, all u=v=0x0100, out_ready=1 -> y00=0x0900, y01=0xFD00, y10=0xFD00, y11=0x0100, with out_valid 2 edges after the handshake.
REQ-033 The bench SHALL check: NUM_CH=4, 4 beats of u[0][0]=0x0200, v[0][0]=0x0180, all other elements 0 -> y00=0x0C00, other y=0, with in_ready low for exactly the XFORM and OUT cycles.
REQ-034 The bench SHALL check: out_ready held 0 for 5 cycles in OUT -> out_valid=1 and y unchanged throughout, in_ready=0, then in_ready=1 the cycle after the handshake.
REQ-035 The bench SHALL check: NUM_CH=1, all u=0x7F00, v=0x0100 -> with WINO_OUT_SAT_EN: y00=0x7FFF, y01=y10=0x8000, y11=0x7F00; without it: y00=0x7700, y01=y10=0x8300, y11=0x7F00.
REQ-036 The bench SHALL check: NUM_CH=4, 2 beats of all-0x0100, rst=1 for 1 cycle, then the REQ-033 stimulus -> y00=0x0C00 (no carry-over).
REQ-037 The bench SHALL check: NUM_CH=4, two back-to-back tiles with in_valid held 1, where tile 2 uses u[0][0]=0x0100, v[0][0]=0x0100 -> tile 2 y00=0x0400 (first-beat overwrite, no residue from tile 1).
